// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// FSM state type and memory word geometry.
package dmem_lsu_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP
    } lsu_state_t;

endpackage

// File: rtl/dmem_lsu_if.sv
// Request, response and data-memory signals of the load/store unit.
// The slave modport is the LSU's view; master is the surrounding pipeline/memory.
interface dmem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/dmem_lsu_align.sv
// Big-endian sub-word datapath: load extraction with sign/zero extension and
// read-modify-write merging of byte/halfword stores into the addressed word.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_load_data  = i_rdata;
        o_merge_data = i_wdata;
        case (i_funct3)
            F3_B: begin
                o_load_data  = {{24{i_rdata[31]}}, i_rdata[31:24]};
                o_merge_data = {i_wdata[7:0], i_rdata[23:0]};
            end
            F3_H: begin
                o_load_data  = {{16{i_rdata[31]}}, i_rdata[31:16]};
                o_merge_data = {i_wdata[15:0], i_rdata[15:0]};
            end
            F3_BU: o_load_data = {24'b0, i_rdata[31:24]};
            F3_HU: o_load_data = {16'b0, i_rdata[31:16]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for a byte-addressed big-endian data memory: one request
// at a time, fault checks at accept, RMW for sub-word stores, held response.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_BYTES   = 512,
    parameter int ALIGN_CHECK = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

    lsu_state_t        r_state;
    logic [2:0]        r_funct3;
    logic [31:0]       r_wdata;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [31:0]       r_mem_wdata;

    logic              w_f3_ok;
    logic              w_misalign;
    logic              w_err;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_data;

    // Unsigned sub-word funct3 codes exist only for loads.
    always_comb begin
        w_f3_ok    = 1'b0;
        w_misalign = 1'b0;
        case (bus.req_funct3)
            F3_B:  w_f3_ok = 1'b1;
            F3_H: begin
                w_f3_ok    = 1'b1;
                w_misalign = bus.req_addr[0];
            end
            F3_W: begin
                w_f3_ok    = 1'b1;
                w_misalign = |bus.req_addr[1:0];
            end
            F3_BU: w_f3_ok = !bus.req_we;
            F3_HU: begin
                w_f3_ok    = !bus.req_we;
                w_misalign = bus.req_addr[0];
            end
            default: ;
        endcase
    end

    assign w_err = !w_f3_ok || (bus.req_addr > LAST_ADDR) || ((ALIGN_CHECK != 0) && w_misalign);

    dmem_lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_rdata      (bus.mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_funct3     <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_funct3    <= bus.req_funct3;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (!bus.req_we) begin
                            r_state    <= S_LOAD;
                            r_mem_addr <= bus.req_addr;
                        end else if (bus.req_funct3 == F3_W) begin
                            r_state     <= S_WRITE;
                            r_mem_addr  <= bus.req_addr;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= bus.req_wdata;
                        end else begin
                            r_state    <= S_MERGE;
                            r_mem_addr <= bus.req_addr;
                        end
                    end
                end
                S_LOAD: begin
                    r_state      <= S_RESP;
                    r_resp_rdata <= w_load_data;
                    r_resp_valid <= 1'b1;
                    r_mem_addr   <= '0;
                end
                S_MERGE: begin
                    r_state     <= S_WRITE;
                    r_mem_wdata <= w_merge_data;
                    r_mem_we    <= 1'b1;
                end
                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_mem_we     <= 1'b0;
                    r_mem_addr   <= '0;
                    r_mem_wdata  <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: vector table for single transactions plus
// hand sequences for response backpressure and reset during a write.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int MEM_BYTES = 512;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        exp_write;
        logic [31:0] exp_wdata;
    } vec_t;

    logic clk;
    logic rst;
    logic [7:0] mem [MEM_BYTES];
    int          we_cnt;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    int          n_vec;
    int          n_err;
    int          idx;
    vec_t        vecs [20];

    dmem_lsu_if #(.ADDR_W(32)) bus ();

    dmem_lsu #(.ADDR_W(32), .MEM_BYTES(MEM_BYTES), .ALIGN_CHECK(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        idx           = 0;
        bus.mem_rdata = '0;
        if (bus.mem_addr <= 32'(MEM_BYTES - 4)) begin
            idx           = int'(bus.mem_addr[8:0]);
            bus.mem_rdata = {mem[idx], mem[idx+1], mem[idx+2], mem[idx+3]};
        end
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            automatic int a = int'(bus.mem_addr[8:0]);
            we_cnt     = we_cnt + 1;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            if (bus.mem_addr <= 32'(MEM_BYTES - 4)) begin
                mem[a]   = bus.mem_wdata[31:24];
                mem[a+1] = bus.mem_wdata[23:16];
                mem[a+2] = bus.mem_wdata[15:8];
                mem[a+3] = bus.mem_wdata[7:0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        @(negedge clk);
        for (k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFC;
        bus.req_wdata = 32'h5555_5555;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int we0;
        bit seen;
        wait_ready(tag);
        we0 = we_cnt;
        drive_req(v.we, v.f3, v.addr, v.wdata);
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            lat = lat + 1;
            if (lat == 1 && !v.exp_err) check({tag, " mem_addr"}, bus.mem_addr, v.addr);
            if (bus.resp_valid) seen = 1'b1;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " rdata"}, bus.resp_rdata, v.exp_rdata);
        check({tag, " err"}, 32'(bus.resp_err), 32'(v.exp_err));
        check({tag, " resp mem_addr"}, bus.mem_addr, 32'h0);
        @(posedge clk);
        #1;
        check({tag, " we pulses"}, 32'(we_cnt - we0), 32'(v.exp_write));
        if (v.exp_write) begin
            check({tag, " waddr"}, last_waddr, v.addr);
            check({tag, " wdata"}, last_wdata, v.exp_wdata);
        end
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        we_cnt         = 0;
        last_waddr     = '0;
        last_wdata     = '0;
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        {mem[16], mem[17], mem[18], mem[19]} = 32'h80FF_1234;
        {mem[48], mem[49], mem[50], mem[51]} = 32'h1122_3344;
        {mem[508], mem[509], mem[510], mem[511]} = 32'h5AA5_C33C;

        //          we    f3     addr          wdata          exp_rdata      err  lat wr   exp_wdata
        vecs[0]  = '{1'b0, F3_B,  32'h10,       32'h0,         32'hFFFF_FF80, 1'b0, 2, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, F3_BU, 32'h10,       32'h0,         32'h0000_0080, 1'b0, 2, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, F3_H,  32'h10,       32'h0,         32'hFFFF_80FF, 1'b0, 2, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, F3_HU, 32'h10,       32'h0,         32'h0000_80FF, 1'b0, 2, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, F3_W,  32'h10,       32'h0,         32'h80FF_1234, 1'b0, 2, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, F3_W,  32'h20,       32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, F3_W,  32'h20,       32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, F3_B,  32'h30,       32'h1234_56AA, 32'h0,         1'b0, 3, 1'b1, 32'hAA22_3344};
        vecs[8]  = '{1'b0, F3_W,  32'h30,       32'h0,         32'hAA22_3344, 1'b0, 2, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, F3_H,  32'h30,       32'hFFFF_BBCC, 32'h0,         1'b0, 3, 1'b1, 32'hBBCC_3344};
        vecs[10] = '{1'b0, F3_W,  32'h30,       32'h0,         32'hBBCC_3344, 1'b0, 2, 1'b0, 32'h0};
        vecs[11] = '{1'b0, F3_W,  32'd508,      32'h0,         32'h5AA5_C33C, 1'b0, 2, 1'b0, 32'h0};
        vecs[12] = '{1'b0, F3_W,  32'd509,      32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[13] = '{1'b0, F3_H,  32'h11,       32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[14] = '{1'b1, F3_BU, 32'h10,       32'h77,        32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 3'b011, 32'h10,      32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[16] = '{1'b0, F3_B,  32'h13,       32'h0,         32'h0000_0034, 1'b0, 2, 1'b0, 32'h0};
        vecs[17] = '{1'b1, F3_W,  32'h22,       32'h1111_1111, 32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[18] = '{1'b0, F3_H,  32'hFFFF_FFF0, 32'h0,        32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[19] = '{1'b0, F3_BU, 32'h31,       32'h0,         32'h0000_00CC, 1'b0, 2, 1'b0, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset resp_err", 32'(bus.resp_err), 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'h0);
        check("reset mem_we", 32'(bus.mem_we), 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        check("reset mem_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: response must hold while writeback stalls.
        begin
            bit seen;
            bus.resp_ready = 1'b0;
            wait_ready("hold");
            drive_req(1'b0, F3_W, 32'h10, 32'h0);
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (bus.resp_valid) seen = 1'b1;
            end
            check("hold first valid", 32'(seen), 32'd1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check($sformatf("hold%0d valid", k), 32'(bus.resp_valid), 32'd1);
                check($sformatf("hold%0d rdata", k), bus.resp_rdata, 32'h80FF_1234);
                check($sformatf("hold%0d req_ready", k), 32'(bus.req_ready), 32'd0);
            end
            bus.resp_ready = 1'b1;
            @(negedge clk);
            check("release req_ready", 32'(bus.req_ready), 32'd1);
            check("release resp_valid", 32'(bus.resp_valid), 32'd0);
            drive_req(1'b0, F3_BU, 32'h10, 32'h0);
            @(negedge clk);
            check("next in LOAD", 32'(bus.resp_valid), 32'd0);
            @(negedge clk);
            check("next resp_valid", 32'(bus.resp_valid), 32'd1);
            check("next rdata", bus.resp_rdata, 32'h0000_0080);
            @(posedge clk);
        end

        // Reset during WRITE of an SW: the write must not commit.
        begin
            int we0;
            wait_ready("rstw");
            we0 = we_cnt;
            drive_req(1'b1, F3_W, 32'h40, 32'h0102_0304);
            @(negedge clk);
            check("rstw mem_we before", 32'(bus.mem_we), 32'd1);
            rst = 1'b0;
            #1;
            check("rstw mem_we", 32'(bus.mem_we), 32'd0);
            check("rstw mem_addr", bus.mem_addr, 32'h0);
            check("rstw mem_wdata", bus.mem_wdata, 32'h0);
            check("rstw req_ready", 32'(bus.req_ready), 32'd1);
            check("rstw resp_valid", 32'(bus.resp_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            check("rstw no write", 32'(we_cnt - we0), 32'd0);
            run_vec('{1'b0, F3_W, 32'h40, 32'h0, 32'h0, 1'b0, 2, 1'b0, 32'h0}, "rstw reload");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
